// File: rtl/axis_change_filter.sv
// AXI-Stream change filter: forwards an input value only when it differs from the last one seen.
// A small output FIFO absorbs backpressure. Define AXIS_CHANGE_FILTER_REFRESH_EN to enable a periodic re-send of the held value.
module axis_change_filter #(
    parameter int DIN_WIDTH      = 16,
    parameter int FIFO_DEPTH     = 4,
    parameter int REFRESH_CYCLES = 1024
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [DIN_WIDTH-1:0]          s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    output logic [DIN_WIDTH-1:0]          m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          clear_overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 and at least 2");
    end
    if (REFRESH_CYCLES < 2) begin : g_bad_refresh
        $error("REFRESH_CYCLES must be at least 2");
    end

    logic                 ready_reg;
    logic [DIN_WIDTH-1:0] last_val_reg, last_val_next;
    logic                 primed_reg, primed_next;
    logic [AW-1:0]        wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]        rd_ptr_reg, rd_ptr_next;
    logic [AW:0]          count_reg, count_next;
    logic                 overflow_reg, overflow_next;

    logic                 in_fire;
    logic                 change;
    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 overwrite;
    logic [AW-1:0]        wr_idx;
    logic [DIN_WIDTH-1:0] push_data;
    logic [DIN_WIDTH-1:0] mem_rd [FIFO_DEPTH];

    assign in_fire = s_axis_tvalid && ready_reg;
    assign change  = in_fire && (!primed_reg || (s_axis_tdata != last_val_reg));

`ifdef AXIS_CHANGE_FILTER_REFRESH_EN
    localparam int RW = $clog2(REFRESH_CYCLES);
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);
    localparam logic [RW-1:0] REFRESH_ONE  = RW'(1);

    logic [RW-1:0] refresh_cnt_reg, refresh_cnt_next;
    logic          refresh_due;

    // A refresh only fires into an empty FIFO; otherwise the counter parks at its last value.
    assign refresh_due = primed_reg && (refresh_cnt_reg == REFRESH_LAST) && (count_reg == '0);
    assign push        = change || refresh_due;
    assign push_data   = change ? s_axis_tdata : last_val_reg;

    always_comb begin
        refresh_cnt_next = refresh_cnt_reg;
        if (push) begin
            refresh_cnt_next = '0;
        end else if (primed_reg && (refresh_cnt_reg != REFRESH_LAST)) begin
            refresh_cnt_next = refresh_cnt_reg + REFRESH_ONE;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            refresh_cnt_reg <= '0;
        end else begin
            refresh_cnt_reg <= refresh_cnt_next;
        end
    end
`else
    assign push      = change;
    assign push_data = s_axis_tdata;
`endif

    assign pop       = (count_reg != '0) && m_axis_tready;
    assign full      = (count_reg == DEPTH_C);
    // Full with no pop: replace the tail; the head stays untouched since depth >= 2.
    assign overwrite = push && full && !pop;
    assign wr_idx    = overwrite ? (wr_ptr_reg - PTR_ONE) : wr_ptr_reg;

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg;
        last_val_next = last_val_reg;
        primed_next   = primed_reg;

        if (push && !overwrite) begin
            wr_ptr_next = wr_ptr_reg + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_ONE;
        end
        if (push && !overwrite && !pop) begin
            count_next = count_reg + CNT_ONE;
        end else if (!push && pop) begin
            count_next = count_reg - CNT_ONE;
        end

        if (overwrite) begin
            overflow_next = 1'b1;
        end else if (clear_overflow) begin
            overflow_next = 1'b0;
        end

        if (change) begin
            last_val_next = s_axis_tdata;
            primed_next   = 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ready_reg    <= 1'b0;
            last_val_reg <= '0;
            primed_reg   <= 1'b0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            ready_reg    <= 1'b1;
            last_val_reg <= last_val_next;
            primed_reg   <= primed_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
        end
    end

    // Entries are cleared on reset so the output data bus reads zero while held in reset.
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
        localparam logic [AW-1:0] IDX = AW'(gi);
        logic [DIN_WIDTH-1:0] entry_reg;

        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                entry_reg <= '0;
            end else if (push && (wr_idx == IDX)) begin
                entry_reg <= push_data;
            end
        end

        assign mem_rd[gi] = entry_reg;
    end

    assign s_axis_tready = ready_reg;
    assign m_axis_tvalid = (count_reg != '0);
    assign m_axis_tdata  = mem_rd[rd_ptr_reg];
    assign fifo_count    = count_reg;
    assign overflow      = overflow_reg;

endmodule

// File: tb/tb_axis_change_filter.sv
// Scoreboard bench for axis_change_filter: expected beats are queued as stimulus is applied
// and compared when the output handshake happens. Refresh build runs the periodic re-send sequence.
module tb_axis_change_filter;

    localparam int W     = 16;
    localparam int DEPTH = 4;
    localparam int RCYC  = 8;

    logic          aclk;
    logic          aresetn;
    logic [W-1:0]  s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [W-1:0]  m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [2:0]    fifo_count;
    logic          overflow;
    logic          clear_overflow;

    axis_change_filter #(
        .DIN_WIDTH      (W),
        .FIFO_DEPTH     (DEPTH),
        .REFRESH_CYCLES (RCYC)
    ) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .fifo_count     (fifo_count),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    typedef struct {
        logic [W-1:0] data;
        int           due;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   extra_beats = 0;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic expect_beat(input logic [W-1:0] data, input int due);
        exp_t e;
        e.data = data;
        e.due  = due;
        sb_q.push_back(e);
    endtask

    task automatic wait_drain(input int max_cycles);
        int n = 0;
        while (sb_q.size() != 0 && n < max_cycles) begin
            tick();
            n++;
        end
        check("drain", 32'(sb_q.size()), 32'd0);
    endtask

    // Output monitor: a beat transfers at the edge following this falling edge (cycle cyc+1).
    always @(negedge aclk) begin
        if (aresetn && m_axis_tvalid && m_axis_tready) begin
            $display("beat data=%h transfer_cycle=%0d", m_axis_tdata, cyc + 1);
            if (sb_q.size() == 0) begin
                extra_beats++;
            end else begin
                mon_e = sb_q.pop_front();
                check("data", 32'(m_axis_tdata), 32'(mon_e.data));
                if (mon_e.due != 0) check("latency", 32'(cyc + 1), 32'(mon_e.due));
            end
        end
    end

    initial begin
        logic [W-1:0] burst [6];
        burst[0] = 16'h00A0; burst[1] = 16'h00B0; burst[2] = 16'h00C0;
        burst[3] = 16'h00D0; burst[4] = 16'h00E0; burst[5] = 16'h00F0;

        aresetn        = 1'b0;
        s_axis_tvalid  = 1'b1;
        s_axis_tdata   = 16'h1234;
        m_axis_tready  = 1'b1;
        clear_overflow = 1'b0;
        repeat (3) tick();

        check("rst_tready",   32'(s_axis_tready), 32'd0);
        check("rst_mvalid",   32'(m_axis_tvalid), 32'd0);
        check("rst_mdata",    32'(m_axis_tdata),  32'd0);
        check("rst_count",    32'(fifo_count),    32'd0);
        check("rst_overflow", 32'(overflow),      32'd0);

`ifdef AXIS_CHANGE_FILTER_REFRESH_EN
        // Constant 0x00AA: first beat, then a re-send every RCYC cycles.
        s_axis_tdata = 16'h00AA;
        aresetn = 1'b1;
        for (int i = 0; i < 4; i++) expect_beat(16'h00AA, cyc + 3 + i * RCYC);
        tick();
        check("tready_up", 32'(s_axis_tready), 32'd1);
        repeat (3 * RCYC + 6) tick();
        check("refresh_pending", 32'(sb_q.size()), 32'd0);
        check("refresh_extra",   32'(extra_beats), 32'd0);
`else
        // Release with a held value: exactly one beat.
        aresetn = 1'b1;
        expect_beat(16'h1234, cyc + 3);
        check("tready_before_edge", 32'(s_axis_tready), 32'd0);
        tick();
        check("tready_up", 32'(s_axis_tready), 32'd1);
        repeat (20) tick();
        check("first_pending", 32'(sb_q.size()), 32'd0);
        check("first_extra",   32'(extra_beats), 32'd0);

        // Three successive changes, each one cycle after its input.
        for (int v = 1; v <= 3; v++) begin
            s_axis_tdata = W'(v);
            expect_beat(W'(v), cyc + 2);
            tick();
        end
        repeat (5) tick();
        check("seq_pending", 32'(sb_q.size()), 32'd0);
        check("seq_extra",   32'(extra_beats), 32'd0);

        // Six changes into a stalled FIFO: tail overwritten, overflow set.
        m_axis_tready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            s_axis_tdata = burst[i];
            tick();
        end
        check("full_count",    32'(fifo_count),   32'd4);
        check("full_overflow", 32'(overflow),     32'd1);
        check("full_head",     32'(m_axis_tdata), 32'(burst[0]));
        expect_beat(burst[0], 0);
        expect_beat(burst[1], 0);
        expect_beat(burst[2], 0);
        expect_beat(burst[5], 0);
        tick();
        check("stall_head", 32'(m_axis_tdata), 32'(burst[0]));

        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);

        // Full FIFO, pop and new change G in the same cycle.
        s_axis_tdata  = 16'h0777;
        m_axis_tready = 1'b1;
        expect_beat(16'h0777, 0);
        tick();
        m_axis_tready = 1'b0;
        check("pushpop_count",    32'(fifo_count),   32'd4);
        check("pushpop_overflow", 32'(overflow),     32'd0);
        check("pushpop_head",     32'(m_axis_tdata), 32'(burst[1]));
        m_axis_tready = 1'b1;
        wait_drain(20);
        check("drain_extra", 32'(extra_beats), 32'd0);

        // Reset with three entries queued; held input re-sent after release.
        m_axis_tready = 1'b0;
        s_axis_tdata = 16'h0101; tick();
        s_axis_tdata = 16'h0202; tick();
        s_axis_tdata = 16'h0303; tick();
        check("q3_count",  32'(fifo_count),    32'd3);
        check("q3_mvalid", 32'(m_axis_tvalid), 32'd1);
        #2;
        aresetn = 1'b0;
        #1;
        check("arst_mvalid", 32'(m_axis_tvalid), 32'd0);
        check("arst_count",  32'(fifo_count),    32'd0);
        check("arst_tready", 32'(s_axis_tready), 32'd0);
        check("arst_mdata",  32'(m_axis_tdata),  32'd0);
        tick();
        tick();
        aresetn       = 1'b1;
        m_axis_tready = 1'b1;
        expect_beat(16'h0303, cyc + 3);
        wait_drain(20);
        repeat (10) tick();
        check("resend_extra", 32'(extra_beats), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axis_change_filter.md
AXIS_CHANGE_FILTER -- requirements
Module: axis_change_filter

Interface
REQ-001 The module SHALL have parameter DIN_WIDTH, default 16, giving the data width in bits.
REQ-002 The module SHALL have parameter FIFO_DEPTH, default 4, giving the output FIFO depth; it must be a power of 2 and at least 2.
REQ-003 The module SHALL have parameter REFRESH_CYCLES, default 1024, giving the refresh interval in aclk cycles; it must be at least 2.
REQ-004 The module SHALL have port aclk  in  1  -- the single clock; all logic is rising-edge.
REQ-005 The module SHALL have port aresetn  in  1  -- reset, asynchronous, active-low.
REQ-006 The module SHALL have port s_axis_tdata  in  DIN_WIDTH  -- the register value, presented as a stream.
REQ-007 The module SHALL have port s_axis_tvalid  in  1  -- input valid; the upstream source may hold it permanently at 1.
REQ-008 The module SHALL have port s_axis_tready  out  1  -- input ready.
REQ-009 The module SHALL have port m_axis_tdata  out  DIN_WIDTH  -- the changed value being forwarded.
REQ-010 The module SHALL have port m_axis_tvalid  out  1  -- output valid.
REQ-011 The module SHALL have port m_axis_tready  in  1  -- downstream ready.
REQ-012 The module SHALL have port fifo_count  out  clog2(FIFO_DEPTH)+1  -- current FIFO occupancy.
REQ-013 The module SHALL have port overflow  out  1  -- sticky flag: a change was merged because the FIFO was full.
REQ-014 The module SHALL have port clear_overflow  in  1  -- synchronous clear of the overflow flag.

Function
REQ-015 The module SHALL drive s_axis_tready to 1 from the first aclk edge after aresetn is released, and SHALL never backpressure the input.
REQ-016 The module SHALL hold internal state last_val (DIN_WIDTH bits) and primed (1 bit).
REQ-017 On a cycle with s_axis_tvalid=1, if primed=0 or s_axis_tdata!=last_val, the module SHALL enqueue s_axis_tdata, set last_val to s_axis_tdata, and set primed to 1.
REQ-018 On a cycle with s_axis_tvalid=1 and s_axis_tdata==last_val, the module SHALL enqueue nothing.
REQ-019 On a cycle with s_axis_tvalid=0, the module SHALL enqueue nothing and SHALL leave last_val unchanged.
REQ-020 Latency SHALL be 1 cycle: a value sampled at edge N into an empty FIFO appears on m_axis_tdata with m_axis_tvalid=1 after edge N+1.
REQ-021 The FIFO SHALL be first-in first-out, and its head SHALL drive m_axis_tdata.
REQ-022 A pop SHALL occur when m_axis_tvalid=1 and m_axis_tready=1.
REQ-023 m_axis_tdata SHALL remain stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-024 m_axis_tvalid SHALL equal (fifo_count!=0).
REQ-025 On a simultaneous push and pop, both SHALL occur and fifo_count SHALL be unchanged; this includes the full and the count=1 cases.
REQ-026 On a push when the FIFO is full and no pop occurs in the same cycle, the module SHALL overwrite the newest (tail) entry with the new value, keep fifo_count at FIFO_DEPTH, and set overflow=1.
REQ-027 The head entry SHALL never be overwritten while m_axis_tvalid=1.
REQ-028 overflow SHALL stay set until clear_overflow=1.
REQ-029 If clear_overflow and a new overflow event occur in the same cycle, overflow SHALL read 1 after the edge (the set wins).
REQ-030 Read and write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-031 While aresetn=0, the module SHALL hold s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, fifo_count=0, overflow=0, primed=0, last_val=0, and the refresh counter at 0.
REQ-032 On reset mid-operation, the module SHALL discard FIFO contents immediately (asynchronously).
REQ-033 After reset release, the first valid input beat SHALL always be forwarded, regardless of its value.

Configuration
REQ-034 The refresh feature SHALL be controlled by the macro AXIS_CHANGE_FILTER_REFRESH_EN.
REQ-035 When AXIS_CHANGE_FILTER_REFRESH_EN is defined, a counter SHALL increment every cycle while primed=1, and SHALL reset to 0 on any enqueue.
REQ-036 When the counter reaches REFRESH_CYCLES-1 and fifo_count=0, the module SHALL enqueue last_val and reset the counter.
REQ-037 When the counter reaches REFRESH_CYCLES-1 and fifo_count!=0, the counter SHALL hold at REFRESH_CYCLES-1 until the FIFO empties.
REQ-038 When a change and a refresh fall due in the same cycle, the module SHALL perform a single enqueue of the new value.
REQ-039 When AXIS_CHANGE_FILTER_REFRESH_EN is undefined, the module SHALL contain no counter and SHALL forward values on change only.

Verification
REQ-040 The bench SHALL release reset with tvalid=1, tdata=0x1234 held, and tready=1, and SHALL check exactly one beat of 0x1234 one cycle after the first sample, then no further beats (refresh off).
REQ-041 The bench SHALL drive tdata 0x0001, 0x0002, 0x0003 on successive cycles with tready=1, and SHALL check three beats in order, each arriving 1 cycle after its input.
REQ-042 The bench SHALL hold tready=0 and apply 6 distinct changes A..F with FIFO_DEPTH=4, and SHALL check fifo_count=4, overflow=1, and drained data A,B,C,F.
REQ-043 The bench SHALL, with the FIFO full, pulse tready=1 in the same cycle as a new change G, and SHALL check that the head pops, G is appended, and overflow does not newly set.
REQ-044 The bench SHALL, with REFRESH_EN defined, REFRESH_CYCLES=8, and constant input 0x00AA, check a repeated beat of 0x00AA every 8 cycles after the first.
REQ-045 The bench SHALL assert aresetn=0 with 3 entries queued, and SHALL check that m_axis_tvalid drops immediately and that the held input is re-sent after release.
